// File: rtl/ysyx_040978_booth_mul_seq.sv
// rtl/ysyx_040978_booth_mul_seq.sv - iterative radix-4 Booth multiplier, 64x64 -> 128, one window per cycle
// Optional BOOTH_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier windows are all zero.

module ysyx_040978_booth_pmgen (
  input  logic [2:0]   y_in,
  input  logic [64:0]  x_in,
  output logic [128:0] p
);
  logic [128:0] w_x;

  assign w_x = {{64{x_in[64]}}, x_in};

  always_comb begin
    p = '0;
    case (y_in)
      3'b001, 3'b010: p = w_x;
      3'b011:         p = w_x << 1;
      3'b100:         p = -(w_x << 1);
      3'b101, 3'b110: p = -w_x;
      default:        p = '0;
    endcase
  end
endmodule

module ysyx_040978_booth_mul_seq #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);
  localparam int ITER = (XLEN + 2) / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [64:0]  r_xr;
  logic [66:0]  r_yr;
  logic [128:0] r_acc;
  logic [5:0]   r_count;

  logic [128:0] w_pp;
  logic [6:0]   w_shamt;
  logic         w_last;
  logic         w_trivial;
  logic         w_x_ext;
  logic         w_y_ext;

  ysyx_040978_booth_pmgen u_pmgen (
    .y_in (r_yr[2:0]),
    .x_in (r_xr),
    .p    (w_pp)
  );

  assign w_shamt = {r_count, 1'b0};
  assign w_last  = (r_count == 6'(ITER - 1));
  assign w_x_ext = mul_signed[1] & multiplicand[XLEN-1];
  assign w_y_ext = mul_signed[0] & multiplier[XLEN-1];

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // All-0 or all-1 remaining windows each select a zero partial product.
  assign w_trivial = (r_yr == '0) || (r_yr == '1);
`else
  assign w_trivial = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next = S_BUSY;
        S_BUSY:  if (w_trivial || w_last) w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Accumulator carries a spare top bit so the full 129-bit partial product is consumed;
  // only bits [127:0] are architecturally visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_xr    <= '0;
      r_yr    <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_xr    <= {w_x_ext, multiplicand};
            r_yr    <= {w_y_ext, w_y_ext, multiplier, 1'b0};
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_BUSY: begin
          if (!w_trivial) begin
            r_acc   <= r_acc + (w_pp << w_shamt);
            r_yr    <= {{2{r_yr[66]}}, r_yr[66:2]};
            r_count <= r_count + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result_hi = r_acc[127:64];
  assign result_lo = r_acc[63:0];
endmodule
